aw_w_stream_packer: RTL and testbench

//  Parametrised write-request packer for the DoCE transaction layer: packs one AW header plus its W beats into a

---
 rtl/aw_w_stream_packer.sv | 200 ++++++++++++++++++++
 tb/tb_aw_w_stream_packer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aw_w_stream_packer.sv
// -----------------------------------------------------------------------------
// aw_w_stream_packer
//
// Packs one AW header and the W beats of its burst into a byte-dense stream of
// OUT_W-bit words. Header bytes come first (little-endian), then every W beat
// in arrival order, with no gaps between them. A byte-fill accumulator
// collects the incoming bytes, and full output words are peeled off its low
// end. The final word of a packet carries a partial keep mask and dout_last.
// Each word also carries the packet's connection id and its total byte count,
// which is derived from the AW len field.
// A beat count that disagrees with the AW len field raises a one-cycle
// err_len pulse. The packet still ends on w_last.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   aw, aw_connection_id header and connection id, aw_valid/aw_ready handshake
//   w, w_last            data beat and burst terminator, w_valid/w_ready
//   dout, dout_keep      packed word (byte 0 in [7:0]) and contiguous byte mask
//   dout_last            final word of the packet
//   dout_valid/ready     output handshake
//   dout_connection_id   connection id of the packet the word belongs to
//   dout_byte_num        HDR_BYTES + (len+1)*W_BYTES, modulo 2^BN_W
//   err_len              one-cycle pulse on a beat-count / w_last mismatch
// -----------------------------------------------------------------------------
module aw_w_stream_packer #(
  parameter int AW_W    = 88,
  parameter int W_W     = 144,
  parameter int OUT_W   = 128,
  parameter int LEN_LSB = 70,
  parameter int LEN_W   = 8,
  parameter int CID_W   = 4,
  parameter int BN_W    = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AW_W-1:0]      aw,
  input  logic [CID_W-1:0]     aw_connection_id,
  input  logic                 aw_valid,
  output logic                 aw_ready,
  input  logic [W_W-1:0]       w,
  input  logic                 w_last,
  input  logic                 w_valid,
  output logic                 w_ready,
  output logic [OUT_W-1:0]     dout,
  output logic [OUT_W/8-1:0]   dout_keep,
  output logic                 dout_last,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [CID_W-1:0]     dout_connection_id,
  output logic [BN_W-1:0]      dout_byte_num,
  output logic                 err_len
);

  localparam int HDR_BYTES = AW_W / 8;
  localparam int W_BYTES   = W_W / 8;
  localparam int OUT_BYTES = OUT_W / 8;
  localparam int ACC_W     = OUT_W + W_W;
  localparam int ACC_BYTES = ACC_W / 8;
  localparam int FILL_W    = $clog2(ACC_BYTES + 1);

  localparam logic [FILL_W-1:0] HDR_F = FILL_W'(HDR_BYTES);
  localparam logic [FILL_W-1:0] W_F   = FILL_W'(W_BYTES);
  localparam logic [FILL_W-1:0] OUT_F = FILL_W'(OUT_BYTES);

  typedef enum logic [1:0] {IDLE, DATA, FLUSH} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [FILL_W-1:0]  fill;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   beat_cnt;
  logic [CID_W-1:0]   cid_q;
  logic [BN_W-1:0]    bn_q;

  logic               aw_hs;
  logic               w_hs;
  logic               slot_free;
  logic               emit;
  logic               last_word;
  logic [FILL_W-1:0]  moved;
  logic [FILL_W-1:0]  fill_after;
  logic [FILL_W-1:0]  fill_next;
  logic [ACC_W-1:0]   acc_next;
  logic [OUT_BYTES-1:0] keep_next;

  // Saturating beat counter increment; a runaway burst must not wrap back
  // to a value that could match len again.
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Bytes to move out of the accumulator this word: a full word, or whatever is left.
  function automatic logic [FILL_W-1:0] take_bytes(input logic [FILL_W-1:0] f);
    return (f >= OUT_F) ? OUT_F : f;
  endfunction

  // Packet byte count from the AW len field, wrapped to BN_W bits.
  function automatic logic [BN_W-1:0] calc_byte_num(input logic [LEN_W-1:0] len);
    logic [31:0] total;
    total = 32'(HDR_BYTES) + (32'(len) + 32'd1) * 32'(W_BYTES);
    return total[BN_W-1:0];
  endfunction

  // Ready signals depend only on registered state, so valid never feeds ready.
  assign aw_ready  = (state == IDLE);
  assign w_ready   = (state == DATA) && (fill < OUT_F);
  assign aw_hs     = aw_valid && aw_ready;
  assign w_hs      = w_valid && w_ready;
  assign slot_free = !dout_valid || dout_ready;

  // In DATA only whole words leave; in FLUSH the remainder drains as well.
  assign emit      = slot_free &&
                     (((state == DATA) && (fill >= OUT_F)) ||
                      ((state == FLUSH) && (fill != '0)));
  assign last_word = (state == FLUSH) && (fill <= OUT_F);

  always_comb begin
    moved      = '0;
    keep_next  = '0;
    if (emit) moved = take_bytes(fill);
    fill_after = fill - moved;
    // Shift first, then drop the new beat just above the bytes that remain.
    acc_next   = acc >> {moved, 3'b000};
    fill_next  = fill_after;
    if (w_hs) begin
      acc_next  = acc_next | (ACC_W'(w) << {fill_after, 3'b000});
      fill_next = fill_after + W_F;
    end
    for (int i = 0; i < OUT_BYTES; i++) begin
      keep_next[i] = (FILL_W'(i) < moved);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      acc                <= '0;
      fill               <= '0;
      len_q              <= '0;
      beat_cnt           <= '0;
      cid_q              <= '0;
      bn_q               <= '0;
      dout               <= '0;
      dout_keep          <= '0;
      dout_last          <= 1'b0;
      dout_valid         <= 1'b0;
      dout_connection_id <= '0;
      dout_byte_num      <= '0;
      err_len            <= 1'b0;
    end else begin
      // A beat is in error if it is the len-th beat without w_last, or
      // carries w_last at any other position.
      err_len <= w_hs && (w_last ^ (beat_cnt == len_q));

      case (state)
        IDLE: begin
          if (aw_hs) begin
            acc      <= ACC_W'(aw);
            fill     <= HDR_F;
            beat_cnt <= '0;
            len_q    <= aw[LEN_LSB +: LEN_W];
            cid_q    <= aw_connection_id;
            bn_q     <= calc_byte_num(aw[LEN_LSB +: LEN_W]);
            state    <= DATA;
          end
        end
        DATA: begin
          acc  <= acc_next;
          fill <= fill_next;
          if (w_hs) begin
            beat_cnt <= sat_inc(beat_cnt);
            if (w_last) state <= FLUSH;
          end
        end
        FLUSH: begin
          acc  <= acc_next;
          fill <= fill_next;
          if (emit && last_word) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Output register stage: load a new word, or retire an accepted one.
      // The id and byte count are copied with each word, so a word held
      // under backpressure keeps its own packet's values even after the
      // next AW has been accepted.
      if (emit) begin
        dout               <= acc[OUT_W-1:0];
        dout_keep          <= keep_next;
        dout_last          <= last_word;
        dout_valid         <= 1'b1;
        dout_connection_id <= cid_q;
        dout_byte_num      <= bn_q;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aw_w_stream_packer.sv
// -----------------------------------------------------------------------------
// tb_aw_w_stream_packer
//
// Bench for aw_w_stream_packer at its default parameters. For each packet,
// the reference model flattens the header and beats into a byte list. It
// then slices the list into 16-byte words with keep/last/cid/byte_num and
// queues them. A monitor pops one entry for every accepted output word. It
// also verifies that held words stay stable and counts err_len pulses.
// -----------------------------------------------------------------------------
module tb_aw_w_stream_packer;

  localparam int AW_W = 88, W_W = 144, OUT_W = 128;
  localparam int HDR_B = 11, W_B = 18, OUT_B = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [AW_W-1:0]   aw;
  logic [3:0]        aw_connection_id;
  logic              aw_valid;
  logic              aw_ready;
  logic [W_W-1:0]    w;
  logic              w_last;
  logic              w_valid;
  logic              w_ready;
  logic [OUT_W-1:0]  dout;
  logic [15:0]       dout_keep;
  logic              dout_last;
  logic              dout_valid;
  logic              dout_ready;
  logic [3:0]        dout_connection_id;
  logic [12:0]       dout_byte_num;
  logic              err_len;

  aw_w_stream_packer dut (
    .clk(clk), .reset(reset),
    .aw(aw), .aw_connection_id(aw_connection_id), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w(w), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .dout(dout), .dout_keep(dout_keep), .dout_last(dout_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_connection_id(dout_connection_id), .dout_byte_num(dout_byte_num),
    .err_len(err_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic [3:0]   cid;
    logic [12:0]  bn;
  } word_t;

  word_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    err_cnt  = 0;
  int    exp_err  = 0;
  bit    mon_en   = 1'b1;
  int    rmode    = 0;
  int    cyc      = 0;
  int    stall_from = -100;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Output ready generator: 0 = always ready, 1 = random, 2 = ready except a
  // 5-cycle stall window starting at stall_from.
  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (rmode)
        1:       dout_ready = ($urandom_range(0, 3) != 0);
        2:       dout_ready = !(cyc >= stall_from && cyc < stall_from + 5);
        default: dout_ready = 1'b1;
      endcase
    end
  end

  // Monitor: scoreboard, hold stability, err_len pulse counting.
  initial begin
    logic              prev_v, prev_r, prev_l;
    logic [OUT_W-1:0]  prev_d;
    logic [15:0]       prev_k;
    word_t             e;
    logic [127:0]      mask;
    prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0; prev_d = '0; prev_k = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_v = 1'b0;
      end else begin
        if (mon_en && prev_v && !prev_r) begin
          check("hold_valid", dout_valid, 1'b1);
          check("hold_data", dout, prev_d);
          check("hold_keep", dout_keep, prev_k);
          check("hold_last", dout_last, prev_l);
        end
        if (mon_en && dout_valid && dout_ready) begin
          check("word_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            mask = '0;
            for (int j = 0; j < 16; j++) if (e.keep[j]) mask[8*j +: 8] = 8'hff;
            check("data", dout & mask, e.data);
            check("keep", dout_keep, e.keep);
            check("last", dout_last, e.last);
            check("cid", dout_connection_id, e.cid);
            check("byte_num", dout_byte_num, e.bn);
          end
        end
        if (mon_en && err_len) err_cnt++;
        prev_v = dout_valid; prev_r = dout_ready; prev_l = dout_last;
        prev_d = dout; prev_k = dout_keep;
      end
    end
  end

  task automatic drive_aw(input logic [AW_W-1:0] a, input logic [3:0] cid);
    int t;
    aw = a; aw_connection_id = cid; aw_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!aw_ready && t < 2000);
    check("aw_handshake", aw_ready, 1'b1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
  endtask

  task automatic drive_w(input logic [W_W-1:0] d, input logic lst, input bit gaps);
    int t;
    int g;
    if (gaps) begin
      g = $urandom_range(0, 2);
      repeat (g) begin @(posedge clk); #1; end
    end
    w = d; w_last = lst; w_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!w_ready && t < 2000);
    check("w_handshake", w_ready, 1'b1);
    @(posedge clk); #1;
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  // Builds the expected word list from the byte stream, then drives the packet.
  task automatic send_packet(input int len, input int nbeats, input logic [3:0] cid, input bit gaps);
    logic [255:0]    tmp;
    logic [AW_W-1:0] a;
    logic [W_W-1:0]  beats[$];
    logic [7:0]      bytes[$];
    word_t           e;
    int              nb;
    tmp = rand_vec();
    a = tmp[AW_W-1:0];
    a[70 +: 8] = len[7:0];
    for (int i = 0; i < HDR_B; i++) bytes.push_back(a[8*i +: 8]);
    for (int b = 0; b < nbeats; b++) begin
      tmp = rand_vec();
      beats.push_back(tmp[W_W-1:0]);
      for (int i = 0; i < W_B; i++) bytes.push_back(tmp[8*i +: 8]);
    end
    nb = bytes.size();
    for (int off = 0; off < nb; off += OUT_B) begin
      e.data = '0; e.keep = '0;
      for (int j = 0; j < OUT_B; j++) begin
        if (off + j < nb) begin
          e.data[8*j +: 8] = bytes[off + j];
          e.keep[j] = 1'b1;
        end
      end
      e.last = (off + OUT_B >= nb);
      e.cid  = cid;
      e.bn   = 13'((HDR_B + (len + 1) * W_B) % 8192);
      exp_q.push_back(e);
    end
    for (int i = 0; i < nbeats; i++) if ((i == nbeats - 1) != (i == len)) exp_err++;
    drive_aw(a, cid);
    for (int b = 0; b < nbeats; b++) drive_w(beats[b], b == nbeats - 1, gaps);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    check("err_len_count", err_cnt, exp_err);
    exp_q.delete();
    err_cnt = 0; exp_err = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] tmp;
    int len, nbt;
    reset = 1'b1; aw = '0; aw_connection_id = '0; aw_valid = 1'b0;
    w = '0; w_last = 1'b0; w_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_dout_keep", dout_keep, 16'h0);
    check("rst_dout_last", dout_last, 1'b0);
    check("rst_err_len", err_len, 1'b0);
    check("rst_byte_num", dout_byte_num, 13'h0);
    check("rst_aw_ready", aw_ready, 1'b1);
    check("rst_w_ready", w_ready, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single beat: 29 bytes -> ffff, 1fff last.
    send_packet(0, 1, 4'h3, 1'b0); drain();
    // Eight beats: 155 bytes -> 9 full words + 07ff.
    send_packet(7, 8, 4'h1, 1'b0); drain();
    // Same with a 5-cycle output stall in the middle.
    rmode = 2;
    fork
      send_packet(7, 8, 4'h6, 1'b0);
      begin repeat (8) @(posedge clk); #1; stall_from = cyc + 1; end
    join
    drain();
    rmode = 0;
    // Early w_last: len 3 but two beats -> 47 bytes, one err_len pulse.
    send_packet(3, 2, 4'h9, 1'b0); drain();
    // Back-to-back packets with distinct ids.
    send_packet(1, 2, 4'h2, 1'b0);
    send_packet(1, 2, 4'h5, 1'b0);
    drain();

    // Reset in the middle of a packet after two beats.
    mon_en = 1'b0;
    tmp = rand_vec();
    tmp[70 +: 8] = 8'd7;
    drive_aw(tmp[AW_W-1:0], 4'hc);
    tmp = rand_vec(); drive_w(tmp[W_W-1:0], 1'b0, 1'b0);
    tmp = rand_vec(); drive_w(tmp[W_W-1:0], 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_dout_valid", dout_valid, 1'b0);
    check("midrst_aw_ready", aw_ready, 1'b1);
    check("midrst_w_ready", w_ready, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    send_packet(0, 1, 4'h7, 1'b0); drain();

    // Random packets, random gaps and backpressure, occasional length errors.
    rmode = 1;
    for (int p = 0; p < 16; p++) begin
      len = $urandom_range(0, 9);
      nbt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len + 2) : len + 1;
      send_packet(len, nbt, 4'($urandom_range(0, 15)), 1'b1);
    end
    drain();
    rmode = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
